instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Fetch-stage sequencer between the program counter register and instruction decode. It reads the registered PC, issues a request to instruction memory with a req/ack handshake, and holds the returned word for decode under a valid/ready handshake. It drives the next-PC value back into the program counter: hold, PC+4, branch target or jump target. It also flags misaligned fetch addresses and counts completed fetches.

## Interface

- PC_STEP, 4: byte increment applied on sequential fetch.

- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- pc_in  in  32  current PC, from the program counter register output.
- pc_next  out  32  combinational next PC, fed to the program counter register input.
- imem_req  out  1  instruction memory request.
- imem_addr  out  32  request address; equals pc_in while imem_req=1.
- imem_ack  in  1  memory completion; imem_rdata is valid in the same cycle.
- imem_rdata  in  32  instruction word.
- instr  out  32  held instruction.
- instr_pc  out  32  PC of the held instruction.
- instr_valid  out  1  instr/instr_pc are valid.
- instr_ready  in  1  decode accepts the held instruction.
- branch_taken  in  1  redirect to branch_target; sampled only on the accept cycle.
- branch_target  in  32  branch destination.
- jump  in  1  redirect to jump_target; sampled only on the accept cycle.
- jump_target  in  32  jump destination.
- fetch_err  out  1  sticky misaligned-fetch flag.
- fetch_count  out  32  number of completed fetches.

## Operation

- States: IDLE, REQ, HOLD, ERR.
- Default: pc_next = pc_in (PC holds).
- IDLE: entered on reset. Goes to REQ on the first clock edge after reset_n deasserts. No request is issued in IDLE.
- REQ, aligned PC (pc_in[1:0]=0):
  - imem_req=1 and imem_addr=pc_in, both stable until ack.
  - On imem_ack:
    - instr<=imem_rdata, instr_pc<=pc_in, instr_valid<=1.
    - pc_next=pc_in+PC_STEP in the same cycle, so the PC register advances on that edge.
    - fetch_count increments.
    - Next state HOLD.
- REQ, misaligned PC (pc_in[1:0]≠0):
  - imem_req=0.
  - fetch_err<=1, next state ERR.
- HOLD:
  - instr_valid=1; instr and instr_pc are stable; imem_req=0.
  - On instr_ready:
    - instr_valid<=0, next state REQ.
    - If jump=1: pc_next=jump_target.
    - Else if branch_taken=1: pc_next=branch_target.
    - Else pc_next=pc_in (the PC is already advanced).
  - Jump has priority over branch.
- ERR: terminal until reset. All outputs hold; imem_req=0, instr_valid=0.
- Ignored inputs:
  - imem_ack outside REQ.
  - branch_taken/jump outside an instr_valid & instr_ready cycle.
  - instr_ready while instr_valid=0.
- Arithmetic:
  - PC+PC_STEP is modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0000_0000.
  - fetch_count wraps from 32'hFFFF_FFFF to 0.
- Misalignment is checked against the redirected PC on the next REQ, not when the target is presented.

## Timing

- Reset (asynchronous, immediate):
  - state=IDLE, imem_req=0, imem_addr=pc_in.
  - instr=0, instr_pc=0, instr_valid=0, fetch_err=0, fetch_count=0.
  - pc_next=pc_in.
- Zero-wait memory (ack in the first REQ cycle) with instr_ready held high: one instruction every 2 cycles (REQ, HOLD).
- With N wait cycles: instr_valid rises N+1 cycles after REQ entry.
- Reset during REQ or HOLD:
  - Any in-flight request is abandoned and a late ack is ignored.
  - The held instruction is dropped.
- Redirect and ready in the same cycle: the PC loads the target on that edge, and the next REQ uses the target address.

## Test plan

- Reset values: assert reset_n=0 mid-HOLD → all outputs return to their reset values immediately; after release, one IDLE cycle, then imem_req=1 with imem_addr=pc_in.
- Sequential fetch: PC reset at 0, zero-wait memory returning 32'h1111_0000+addr, instr_ready=1 → instr_pc sequence 0, 4, 8, 12; instr matches; fetch_count=4 after 8 cycles.
- Wait states and backpressure:
  - ack 3 cycles after request → imem_addr stays stable for all 3 cycles and pc_next=pc_in until ack.
  - instr_ready low for 4 cycles → instr/instr_pc stable and no new request.
- Redirect: accept at instr_pc=0x8 with branch_taken=1, branch_target=0x40 → next imem_addr=0x40. Then accept with jump=1 (0x100) and branch_taken=1 (0x200) together → next imem_addr=0x100.
- Misaligned: jump_target=0x102 → next REQ cycle imem_req=0, fetch_err=1, state stuck in ERR, further acks ignored until reset.
- Wrap: PC=32'hFFFF_FFFC fetched → pc_next=0 and the next imem_addr=0.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - fetch unit bus: PC loop, imem req/ack, decode valid/ready, redirect
interface instr_fetch_unit_if;
  logic [31:0] pc_in;
  logic [31:0] pc_next;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        fetch_err;
  logic [31:0] fetch_count;

  modport master (
    input  pc_in, imem_ack, imem_rdata, instr_ready,
           branch_taken, branch_target, jump, jump_target,
    output pc_next, imem_req, imem_addr, instr, instr_pc, instr_valid,
           fetch_err, fetch_count
  );

  modport slave (
    output pc_in, imem_ack, imem_rdata, instr_ready,
           branch_taken, branch_target, jump, jump_target,
    input  pc_next, imem_req, imem_addr, instr, instr_pc, instr_valid,
           fetch_err, fetch_count
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch sequencer: PC -> imem request -> held instruction for decode
module instr_fetch_unit #(
  parameter logic [31:0] PC_STEP = 32'd4
) (
  input  logic              clk,
  input  logic              reset_n,
  instr_fetch_unit_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, ERR} state_t;

  state_t      state;
  logic [31:0] instr_q;
  logic [31:0] instr_pc_q;
  logic        instr_valid_q;
  logic        fetch_err_q;
  logic [31:0] fetch_count_q;

  logic aligned;
  logic fetch_done;
  logic accept;

  assign aligned    = (bus.pc_in[1:0] == 2'b00);
  assign fetch_done = (state == REQ) && aligned && bus.imem_ack;
  assign accept     = (state == HOLD) && bus.instr_ready;

  assign bus.imem_req    = (state == REQ) && aligned;
  assign bus.imem_addr   = bus.pc_in;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.fetch_err   = fetch_err_q;
  assign bus.fetch_count = fetch_count_q;

  // The PC register advances on the ack edge, so an accept without redirect just holds it.
  always_comb begin
    bus.pc_next = bus.pc_in;
    if (fetch_done) begin
      bus.pc_next = bus.pc_in + PC_STEP;
    end else if (accept) begin
      if (bus.jump)
        bus.pc_next = bus.jump_target;
      else if (bus.branch_taken)
        bus.pc_next = bus.branch_target;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      instr_q       <= 32'd0;
      instr_pc_q    <= 32'd0;
      instr_valid_q <= 1'b0;
      fetch_err_q   <= 1'b0;
      fetch_count_q <= 32'd0;
    end else begin
      case (state)
        IDLE: state <= REQ;
        REQ: begin
          if (!aligned) begin
            fetch_err_q <= 1'b1;
            state       <= ERR;
          end else if (bus.imem_ack) begin
            instr_q       <= bus.imem_rdata;
            instr_pc_q    <= bus.pc_in;
            instr_valid_q <= 1'b1;
            fetch_count_q <= fetch_count_q + 32'd1;
            state         <= HOLD;
          end
        end
        HOLD: begin
          if (bus.instr_ready) begin
            instr_valid_q <= 1'b0;
            state         <= REQ;
          end
        end
        ERR: state <= ERR;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [31:0] pc_rst = 32'd0;
  int          n_tests = 0;
  int          n_fail = 0;

  instr_fetch_unit_if bus ();

  instr_fetch_unit dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Program counter register that closes the pc_next -> pc_in loop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) bus.pc_in <= pc_rst;
    else          bus.pc_in <= bus.pc_next;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_redirect();
    bus.branch_taken  = 1'b0;
    bus.branch_target = 32'd0;
    bus.jump          = 1'b0;
    bus.jump_target   = 32'd0;
  endtask

  initial begin
    bus.imem_ack    = 1'b0;
    bus.imem_rdata  = 32'd0;
    bus.instr_ready = 1'b0;
    clear_redirect();

    // Power-on reset
    #1 reset_n = 1'b0;
    #1;
    check("rst_instr", bus.instr, 32'd0);
    check("rst_instr_pc", bus.instr_pc, 32'd0);
    check("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
    check("rst_err", {31'd0, bus.fetch_err}, 32'd0);
    check("rst_count", bus.fetch_count, 32'd0);
    check("rst_req", {31'd0, bus.imem_req}, 32'd0);
    check("rst_pc_next", bus.pc_next, 32'd0);
    cycle();
    cycle();
    reset_n = 1'b1;
    #1;
    check("idle_req", {31'd0, bus.imem_req}, 32'd0);
    cycle();
    check("first_req", {31'd0, bus.imem_req}, 32'd1);
    check("first_addr", bus.imem_addr, 32'd0);

    // Sequential zero-wait fetch, decode always ready
    for (int i = 0; i < 4; i++) begin
      check("seq_req", {31'd0, bus.imem_req}, 32'd1);
      check("seq_addr", bus.imem_addr, 32'(4 * i));
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = 32'h1111_0000 + 32'(4 * i);
      #1;
      check("seq_pc_next_ack", bus.pc_next, 32'(4 * i + 4));
      cycle();
      bus.imem_ack    = 1'b0;
      bus.instr_ready = 1'b1;
      #1;
      check("seq_valid", {31'd0, bus.instr_valid}, 32'd1);
      check("seq_instr", bus.instr, 32'h1111_0000 + 32'(4 * i));
      check("seq_instr_pc", bus.instr_pc, 32'(4 * i));
      check("seq_count", bus.fetch_count, 32'(i + 1));
      check("seq_hold_req", {31'd0, bus.imem_req}, 32'd0);
      check("seq_pc_next_acc", bus.pc_next, 32'(4 * i + 4));
      cycle();
    end
    check("seq_count_final", bus.fetch_count, 32'd4);

    // Three wait cycles before ack
    bus.instr_ready = 1'b0;
    for (int w = 0; w < 3; w++) begin
      check("wait_req", {31'd0, bus.imem_req}, 32'd1);
      check("wait_addr", bus.imem_addr, 32'h10);
      check("wait_pc_next", bus.pc_next, 32'h10);
      check("wait_valid", {31'd0, bus.instr_valid}, 32'd0);
      cycle();
    end
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h1111_0010;
    #1;
    check("wait_pc_next_ack", bus.pc_next, 32'h14);
    cycle();
    check("wait_valid_rise", {31'd0, bus.instr_valid}, 32'd1);
    check("wait_instr_pc", bus.instr_pc, 32'h10);

    // Backpressure with stray ack and redirects that must be ignored
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h40;
    bus.jump          = 1'b1;
    bus.jump_target   = 32'h80;
    for (int b = 0; b < 4; b++) begin
      #1;
      check("bp_instr", bus.instr, 32'h1111_0010);
      check("bp_instr_pc", bus.instr_pc, 32'h10);
      check("bp_valid", {31'd0, bus.instr_valid}, 32'd1);
      check("bp_req", {31'd0, bus.imem_req}, 32'd0);
      check("bp_pc_next", bus.pc_next, 32'h14);
      check("bp_count", bus.fetch_count, 32'd5);
      cycle();
    end

    // Reset mid-HOLD, with ack still high across reset and IDLE
    clear_redirect();
    pc_rst  = 32'h8;
    reset_n = 1'b0;
    #1;
    check("mid_rst_instr", bus.instr, 32'd0);
    check("mid_rst_instr_pc", bus.instr_pc, 32'd0);
    check("mid_rst_valid", {31'd0, bus.instr_valid}, 32'd0);
    check("mid_rst_count", bus.fetch_count, 32'd0);
    check("mid_rst_req", {31'd0, bus.imem_req}, 32'd0);
    check("mid_rst_pc_next", bus.pc_next, 32'h8);
    check("mid_rst_addr", bus.imem_addr, 32'h8);
    cycle();
    reset_n = 1'b1;
    #1;
    check("rel_idle_req", {31'd0, bus.imem_req}, 32'd0);
    cycle();
    check("rel_idle_count", bus.fetch_count, 32'd0);
    check("rel_req", {31'd0, bus.imem_req}, 32'd1);
    check("rel_addr", bus.imem_addr, 32'h8);

    // Branch redirect on accept at instr_pc 0x8
    bus.imem_rdata = 32'h1111_0008;
    #1;
    check("br_pc_next_ack", bus.pc_next, 32'hC);
    cycle();
    bus.imem_ack      = 1'b0;
    bus.instr_ready   = 1'b1;
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h40;
    #1;
    check("br_instr_pc", bus.instr_pc, 32'h8);
    check("br_instr", bus.instr, 32'h1111_0008);
    check("br_pc_next", bus.pc_next, 32'h40);
    cycle();
    clear_redirect();
    bus.instr_ready = 1'b0;
    check("br_addr", bus.imem_addr, 32'h40);
    check("br_req", {31'd0, bus.imem_req}, 32'd1);

    // Jump beats branch
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h1111_0040;
    cycle();
    bus.imem_ack      = 1'b0;
    bus.instr_ready   = 1'b1;
    bus.jump          = 1'b1;
    bus.jump_target   = 32'h100;
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h200;
    #1;
    check("jb_instr_pc", bus.instr_pc, 32'h40);
    check("jb_pc_next", bus.pc_next, 32'h100);
    cycle();
    clear_redirect();
    bus.instr_ready = 1'b0;
    check("jb_addr", bus.imem_addr, 32'h100);

    // Jump to a misaligned target
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h1111_0100;
    cycle();
    bus.imem_ack    = 1'b0;
    bus.instr_ready = 1'b1;
    bus.jump        = 1'b1;
    bus.jump_target = 32'h102;
    #1;
    check("mis_count_pre", bus.fetch_count, 32'd3);
    check("mis_pc_next", bus.pc_next, 32'h102);
    cycle();
    clear_redirect();
    bus.instr_ready = 1'b0;
    check("mis_req", {31'd0, bus.imem_req}, 32'd0);
    check("mis_addr", bus.imem_addr, 32'h102);
    check("mis_err_pre", {31'd0, bus.fetch_err}, 32'd0);
    bus.imem_ack    = 1'b1;
    bus.imem_rdata  = 32'hDEAD_BEEF;
    bus.instr_ready = 1'b1;
    #1;
    check("mis_pc_hold", bus.pc_next, 32'h102);
    cycle();
    check("err_flag", {31'd0, bus.fetch_err}, 32'd1);
    check("err_valid", {31'd0, bus.instr_valid}, 32'd0);
    check("err_req", {31'd0, bus.imem_req}, 32'd0);
    cycle();
    cycle();
    check("err_count", bus.fetch_count, 32'd3);
    check("err_flag_sticky", {31'd0, bus.fetch_err}, 32'd1);
    check("err_instr", bus.instr, 32'h1111_0100);
    check("err_instr_pc", bus.instr_pc, 32'h100);
    check("err_pc_next", bus.pc_next, 32'h102);
    check("err_req_hold", {31'd0, bus.imem_req}, 32'd0);

    // PC wrap at the top of the address space
    bus.imem_ack    = 1'b0;
    bus.instr_ready = 1'b0;
    pc_rst  = 32'hFFFF_FFFC;
    reset_n = 1'b0;
    #1;
    check("wrap_rst_err", {31'd0, bus.fetch_err}, 32'd0);
    cycle();
    reset_n = 1'b1;
    cycle();
    check("wrap_req", {31'd0, bus.imem_req}, 32'd1);
    check("wrap_addr", bus.imem_addr, 32'hFFFF_FFFC);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h1234_5678;
    #1;
    check("wrap_pc_next", bus.pc_next, 32'h0);
    cycle();
    bus.imem_ack    = 1'b0;
    bus.instr_ready = 1'b1;
    #1;
    check("wrap_instr_pc", bus.instr_pc, 32'hFFFF_FFFC);
    check("wrap_instr", bus.instr, 32'h1234_5678);
    cycle();
    bus.instr_ready = 1'b0;
    check("wrap_next_addr", bus.imem_addr, 32'h0);
    check("wrap_next_req", {31'd0, bus.imem_req}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
